// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: scans a slot table one entry per cycle and
// resolves note-on/note-off events into registered voice_controller writes.
module voice_allocator #(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned VIDX_W     = 3,
  parameter int unsigned AGE_W      = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_evt_valid,
  output logic              o_evt_ready,
  input  logic              i_evt_note_on,
  input  logic [6:0]        i_evt_note,
  input  logic [6:0]        i_evt_velocity,
  output logic              o_voice_valid,
  output logic [7:0]        o_voice_index,
  output logic              o_voice_status,
  output logic [6:0]        o_voice_note,
  output logic [6:0]        o_voice_velocity,
  output logic              o_voice_steal,
  output logic [VIDX_W:0]   o_active_count
);

  localparam int unsigned CNT_W = VIDX_W + 1;
  localparam logic [AGE_W-1:0]  AGE_MAX   = '1;
  localparam logic [VIDX_W-1:0] LAST_SLOT = VIDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, ISSUE} state_t;

  state_t state_q, state_d;

  // Slot table
  logic             slot_active [NUM_VOICES];
  logic [6:0]       slot_note   [NUM_VOICES];
  logic [AGE_W-1:0] slot_age    [NUM_VOICES];

  // Latched event and scan bookkeeping
  logic [VIDX_W-1:0] scan_q, scan_d;
  logic              evt_on_q, evt_on_d;
  logic [6:0]        evt_note_q, evt_note_d;
  logic [6:0]        evt_vel_q, evt_vel_d;
  logic              match_found_q, match_found_d;
  logic [VIDX_W-1:0] match_idx_q, match_idx_d;
  logic              free_found_q, free_found_d;
  logic [VIDX_W-1:0] free_idx_q, free_idx_d;
  logic [VIDX_W-1:0] old_idx_q, old_idx_d;
  logic [AGE_W-1:0]  old_age_q, old_age_d;

  // Table update controls
  logic              do_on, do_off;
  logic [VIDX_W-1:0] tgt_idx;

  // Next values of registered outputs
  logic              ready_d, valid_d, status_d, steal_d;
  logic [VIDX_W-1:0] vidx_q, vidx_d;
  logic [6:0]        note_d, vel_d;
  logic [CNT_W-1:0]  count_d;

  assign o_voice_index = 8'(vidx_q);

  // Next-state, scan bookkeeping and output staging
  always_comb begin
    state_d       = state_q;
    scan_d        = scan_q;
    evt_on_d      = evt_on_q;
    evt_note_d    = evt_note_q;
    evt_vel_d     = evt_vel_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    old_idx_d     = old_idx_q;
    old_age_d     = old_age_q;
    do_on         = 1'b0;
    do_off        = 1'b0;
    tgt_idx       = '0;
    valid_d       = 1'b0;
    steal_d       = 1'b0;
    status_d      = o_voice_status;
    vidx_d        = vidx_q;
    note_d        = o_voice_note;
    vel_d         = o_voice_velocity;
    count_d       = o_active_count;

    unique case (state_q)
      IDLE: begin
        if (i_evt_valid && o_evt_ready) begin
          // Zero-velocity note-on is a note-off by MIDI convention
          evt_on_d      = i_evt_note_on && (i_evt_velocity != 7'd0);
          evt_note_d    = i_evt_note;
          evt_vel_d     = i_evt_velocity;
          scan_d        = '0;
          match_found_d = 1'b0;
          free_found_d  = 1'b0;
          old_idx_d     = '0;
          old_age_d     = '0;
          state_d       = SCAN;
        end
      end
      SCAN: begin
        if (slot_active[scan_q] && (slot_note[scan_q] == evt_note_q) && !match_found_q) begin
          match_found_d = 1'b1;
          match_idx_d   = scan_q;
        end
        if (!slot_active[scan_q] && !free_found_q) begin
          free_found_d = 1'b1;
          free_idx_d   = scan_q;
        end
        // Strict compare keeps the lowest index on age ties
        if ((scan_q == '0) || (slot_age[scan_q] > old_age_q)) begin
          old_idx_d = scan_q;
          old_age_d = slot_age[scan_q];
        end
        scan_d = scan_q + VIDX_W'(1);
        if (scan_q == LAST_SLOT) state_d = ISSUE;
      end
      ISSUE: begin
        state_d = IDLE;
        if (evt_on_q) begin
          do_on    = 1'b1;
          tgt_idx  = match_found_q ? match_idx_q : (free_found_q ? free_idx_q : old_idx_q);
          valid_d  = 1'b1;
          steal_d  = !match_found_q && !free_found_q;
          status_d = 1'b1;
          vidx_d   = tgt_idx;
          note_d   = evt_note_q;
          vel_d    = evt_vel_q;
          if (!match_found_q && free_found_q) count_d = o_active_count + CNT_W'(1);
        end else if (match_found_q) begin
          do_off   = 1'b1;
          tgt_idx  = match_idx_q;
          valid_d  = 1'b1;
          status_d = 1'b0;
          vidx_d   = tgt_idx;
          note_d   = evt_note_q;
          vel_d    = 7'd0;
          count_d  = o_active_count - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  // State, event latch and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q          <= IDLE;
      scan_q           <= '0;
      evt_on_q         <= 1'b0;
      evt_note_q       <= '0;
      evt_vel_q        <= '0;
      match_found_q    <= 1'b0;
      match_idx_q      <= '0;
      free_found_q     <= 1'b0;
      free_idx_q       <= '0;
      old_idx_q        <= '0;
      old_age_q        <= '0;
      o_evt_ready      <= 1'b1;
      o_voice_valid    <= 1'b0;
      o_voice_status   <= 1'b0;
      o_voice_note     <= '0;
      o_voice_velocity <= '0;
      o_voice_steal    <= 1'b0;
      o_active_count   <= '0;
      vidx_q           <= '0;
    end else begin
      state_q          <= state_d;
      scan_q           <= scan_d;
      evt_on_q         <= evt_on_d;
      evt_note_q       <= evt_note_d;
      evt_vel_q        <= evt_vel_d;
      match_found_q    <= match_found_d;
      match_idx_q      <= match_idx_d;
      free_found_q     <= free_found_d;
      free_idx_q       <= free_idx_d;
      old_idx_q        <= old_idx_d;
      old_age_q        <= old_age_d;
      o_evt_ready      <= ready_d;
      o_voice_valid    <= valid_d;
      o_voice_status   <= status_d;
      o_voice_note     <= note_d;
      o_voice_velocity <= vel_d;
      o_voice_steal    <= steal_d;
      o_active_count   <= count_d;
      vidx_q           <= vidx_d;
    end
  end

  // Slot table update; note-on ages every other active slot
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (i_reset) begin
        slot_active[i] <= 1'b0;
        slot_note[i]   <= '0;
        slot_age[i]    <= '0;
      end else if (do_on) begin
        if (VIDX_W'(i) == tgt_idx) begin
          slot_active[i] <= 1'b1;
          slot_note[i]   <= evt_note_q;
          slot_age[i]    <= '0;
        end else if (slot_active[i] && (slot_age[i] != AGE_MAX)) begin
          slot_age[i] <= slot_age[i] + AGE_W'(1);
        end
      end else if (do_off && (VIDX_W'(i) == tgt_idx)) begin
        slot_active[i] <= 1'b0;
        slot_age[i]    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: directed events push expected strobes,
// an independent monitor pops and compares each strobe as it appears.
module tb_voice_allocator;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       evt_valid;
  logic       evt_ready;
  logic       evt_note_on;
  logic [6:0] evt_note;
  logic [6:0] evt_vel;
  logic       voice_valid;
  logic [7:0] voice_index;
  logic       voice_status;
  logic [6:0] voice_note;
  logic [6:0] voice_vel;
  logic       voice_steal;
  logic [3:0] active_count;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] idx;
    logic       st;
    logic [6:0] note;
    logic [6:0] vel;
    logic       steal;
    logic [3:0] cnt;
    int         at;
  } exp_t;

  exp_t sb[$];

  voice_allocator #(.NUM_VOICES(8), .VIDX_W(3), .AGE_W(8)) dut (
    .i_clk           (clk),
    .i_reset         (i_reset),
    .i_evt_valid     (evt_valid),
    .o_evt_ready     (evt_ready),
    .i_evt_note_on   (evt_note_on),
    .i_evt_note      (evt_note),
    .i_evt_velocity  (evt_vel),
    .o_voice_valid   (voice_valid),
    .o_voice_index   (voice_index),
    .o_voice_status  (voice_status),
    .o_voice_note    (voice_note),
    .o_voice_velocity(voice_vel),
    .o_voice_steal   (voice_steal),
    .o_active_count  (active_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every strobe against the head of the scoreboard
  always @(negedge clk) begin
    if (voice_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("strobe_cycle", cyc, e.at);
        check("voice_index", int'(voice_index), int'(e.idx));
        check("voice_status", int'(voice_status), int'(e.st));
        check("voice_note", int'(voice_note), int'(e.note));
        check("voice_velocity", int'(voice_vel), int'(e.vel));
        check("voice_steal", int'(voice_steal), int'(e.steal));
        check("active_count", int'(active_count), int'(e.cnt));
      end
    end
  end

  task automatic do_reset();
    i_reset   = 1'b1;
    evt_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 i_reset = 1'b0;
  endtask

  // Present one event; when exp_strobe is set, push the hand-computed strobe
  task automatic send(input logic on, input logic [6:0] note, input logic [6:0] vel,
                      input logic exp_strobe, input logic [7:0] eidx, input logic est,
                      input logic [6:0] evel, input logic esteal, input logic [3:0] ecnt,
                      input bit hold);
    int n;
    exp_t e;
    evt_valid   = 1'b1;
    evt_note_on = on;
    evt_note    = note;
    evt_vel     = vel;
    n = 0;
    while (!evt_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    if (exp_strobe) begin
      e = '{eidx, est, note, evel, esteal, ecnt, cyc + 9};
      sb.push_back(e);
    end
    if (!hold) evt_valid = 1'b0;
    n = 0;
    while (!evt_ready && n < 50) begin
      n++; @(posedge clk); #1;
    end
    check("ready_low_cycles", n, 9);
  endtask

  initial begin
    i_reset     = 1'b1;
    evt_valid   = 1'b0;
    evt_note_on = 1'b0;
    evt_note    = '0;
    evt_vel     = '0;
    do_reset();

    check("reset_ready", int'(evt_ready), 1);
    check("reset_valid", int'(voice_valid), 0);
    check("reset_index", int'(voice_index), 0);
    check("reset_status", int'(voice_status), 0);
    check("reset_note", int'(voice_note), 0);
    check("reset_velocity", int'(voice_vel), 0);
    check("reset_steal", int'(voice_steal), 0);
    check("reset_count", int'(active_count), 0);

    // Single note-on
    send(1, 60, 100, 1, 0, 1, 100, 0, 1, 0);

    // Free-slot allocation and release, then reuse of the freed slot
    do_reset();
    send(1, 60, 100, 1, 0, 1, 100, 0, 1, 0);
    send(1, 62, 101, 1, 1, 1, 101, 0, 2, 0);
    send(1, 64, 102, 1, 2, 1, 102, 0, 3, 0);
    send(0, 62, 50,  1, 1, 0, 0,   0, 2, 0);
    send(1, 65, 90,  1, 1, 1, 90,  0, 3, 0);
    check("index_hold", int'(voice_index), 1);

    // Fill all voices, then steal oldest twice
    do_reset();
    for (int i = 0; i < 8; i++)
      send(1, 7'(60 + i), 7'(10 + i), 1, 8'(i), 1, 7'(10 + i), 0, 4'(i + 1), 0);
    send(1, 70, 80, 1, 0, 1, 80, 1, 8, 0);
    send(1, 71, 81, 1, 1, 1, 81, 1, 8, 0);

    // Retrigger, zero-velocity note-on unmatched, unmatched off, matched off
    do_reset();
    send(1, 60, 100, 1, 0, 1, 100, 0, 1, 0);
    send(1, 60, 50,  1, 0, 1, 50,  0, 1, 0);
    send(1, 61, 0,   0, 0, 0, 0,   0, 0, 0);
    send(0, 99, 20,  0, 0, 0, 0,   0, 0, 0);
    check("count_after_unmatched", int'(active_count), 1);
    send(0, 60, 20,  1, 0, 0, 0,   0, 0, 0);

    // Back-to-back with valid held through busy cycles
    do_reset();
    send(1, 40, 11, 1, 0, 1, 11, 0, 1, 1);
    send(1, 41, 12, 1, 1, 1, 12, 0, 2, 1);
    send(1, 42, 13, 1, 2, 1, 13, 0, 3, 1);
    evt_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("count_after_burst", int'(active_count), 3);

    // Reset in the middle of a scan aborts the event
    evt_valid   = 1'b1;
    evt_note_on = 1'b1;
    evt_note    = 7'd50;
    evt_vel     = 7'd60;
    @(posedge clk); #1;
    evt_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 i_reset = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    check("midscan_ready", int'(evt_ready), 1);
    check("midscan_count", int'(active_count), 0);
    check("midscan_valid", int'(voice_valid), 0);
    repeat (15) @(posedge clk);
    #1;

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
